// File: rtl/rr_hot_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The arbiter is the slave; the requester side is the master.
interface rr_hot_arbiter_if #(
    parameter int N_REQ = 7
);
    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    logic [2:0]       grant_idx;
    logic [2:0]       grant_code;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_code,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_code,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_hot_arbiter.sv
// Round-robin arbiter with registered one-hot grant, 1-based grant index,
// optional Gray-coded index, and a bounded grant tenure.
//
// state | meaning
// IDLE  | no grant; next edge picks a winner from ptr upward if any req is set
// GRANT | grant held for winner; released on req drop, done, or MAX_HOLD
module rr_hot_arbiter #(
    parameter int N_REQ    = 7,
    parameter int MAX_HOLD = 4,
    parameter bit USE_GRAY = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_hot_arbiter_if.slave bus
);
    localparam int TW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [2:0]    ptr;
    logic [2:0]    winner;
    logic [TW-1:0] tenure;

    logic          found;
    logic [2:0]    pick;
    logic          release_now;

    function automatic logic [2:0] encode(input logic [2:0] idx);
        return USE_GRAY ? (idx ^ (idx >> 1)) : idx;
    endfunction

    // Rotating search: first set request at or above ptr, wrapping to 0.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && bus.req[j]) begin
                found = 1'b1;
                pick  = 3'(j);
            end
        end
    end

    assign release_now = !bus.req[winner] || bus.done || (tenure == TW'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= 3'd0;
            winner         <= 3'd0;
            tenure         <= '0;
            bus.grant      <= '0;
            bus.grant_idx  <= 3'd0;
            bus.grant_code <= 3'd0;
            bus.busy       <= 1'b0;
            bus.timeout    <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state          <= GRANT;
                        winner         <= pick;
                        tenure         <= TW'(1);
                        bus.grant      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                        bus.grant_idx  <= pick + 3'd1;
                        bus.grant_code <= encode(pick + 3'd1);
                        bus.busy       <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state          <= IDLE;
                        bus.grant      <= '0;
                        bus.grant_idx  <= 3'd0;
                        bus.grant_code <= 3'd0;
                        bus.busy       <= 1'b0;
                        ptr            <= (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
                        // Only a pure tenure expiry counts as a timeout.
                        bus.timeout    <= bus.req[winner] && !bus.done;
                    end else begin
                        tenure <= tenure + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_hot_arbiter.sv
// Scoreboard bench: a plain-integer round-robin model predicts every cycle of
// a binary-index DUT and a Gray-index DUT driven by the same stimulus.
module tb_rr_hot_arbiter;
    localparam int N   = 7;
    localparam int MH  = 4;

    logic clk;
    logic rst_n;

    rr_hot_arbiter_if #(.N_REQ(N)) bus0 ();
    rr_hot_arbiter_if #(.N_REQ(N)) bus1 ();

    assign bus1.req  = bus0.req;
    assign bus1.done = bus0.done;

    rr_hot_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .USE_GRAY(1'b0)) dut_bin (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    rr_hot_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .USE_GRAY(1'b1)) dut_gray (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [2:0]   idx;
        logic [2:0]   gray;
        logic         busy;
        logic         timeout;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: holder = -1 means nobody owns the resource.
    int m_holder, m_ptr, m_ten;
    bit m_to;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_holder = -1; m_ptr = 0; m_ten = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic d);
        m_to = 0;
        if (m_holder < 0) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (m_holder < 0 && r[c]) begin
                    m_holder = c;
                    m_ten = 1;
                end
            end
        end else begin
            if (!r[m_holder] || d || m_ten == MH) begin
                m_to = r[m_holder] && !d;
                m_ptr = (m_holder + 1) % N;
                m_holder = -1;
            end else begin
                m_ten++;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int k;
        k = m_holder + 1;
        e.grant   = (m_holder >= 0) ? (N'(1) << m_holder) : '0;
        e.idx     = 3'(k);
        e.gray    = 3'(k ^ (k >> 1));
        e.busy    = (m_holder >= 0);
        e.timeout = m_to;
        return e;
    endfunction

    // Drive one cycle's inputs, predict the outcome of the next edge, then advance.
    task automatic cyc(input logic [N-1:0] r, input logic d);
        bus0.req  = r;
        bus0.done = d;
        model_step(r, d);
        q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, int'(bus0.grant), 0);
        chk({tag, "_idx"},   int'(bus0.grant_idx), 0);
        chk({tag, "_code"},  int'(bus0.grant_code), 0);
        chk({tag, "_busy"},  int'(bus0.busy), 0);
        chk({tag, "_to"},    int'(bus0.timeout), 0);
        chk({tag, "_gcode"}, int'(bus1.grant_code), 0);
        chk({tag, "_ggrant"}, int'(bus1.grant), 0);
    endtask

    // Monitor: one DUT output set per edge, compared 1 time unit after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("grant",      int'(bus0.grant),      int'(e.grant));
                chk("grant_idx",  int'(bus0.grant_idx),  int'(e.idx));
                chk("grant_code", int'(bus0.grant_code), int'(e.idx));
                chk("busy",       int'(bus0.busy),       int'(e.busy));
                chk("timeout",    int'(bus0.timeout),    int'(e.timeout));
                chk("gray_grant", int'(bus1.grant),      int'(e.grant));
                chk("gray_code",  int'(bus1.grant_code), int'(e.gray));
                chk("gray_to",    int'(bus1.timeout),    int'(e.timeout));
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic         d;
        rst_n     = 1'b0;
        bus0.req  = 7'h7F;
        bus0.done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst_n    = 1'b1;
        bus0.req = '0;

        repeat (3) cyc('0, 1'b0);

        // Single request, dropped once granted.
        cyc(7'b0000100, 1'b0);
        cyc(7'b0000100, 1'b0);
        cyc(7'b0000000, 1'b0);
        cyc(7'b0000000, 1'b0);

        // All requesting: full rotation with tenure expiry.
        repeat (45) cyc(7'h7F, 1'b0);
        repeat (2) cyc('0, 1'b0);

        // Park ptr at 6, then wrap and release by done.
        cyc(7'b0100000, 1'b0);
        cyc(7'b0000000, 1'b0);
        cyc(7'b1000001, 1'b0);
        cyc(7'b1000001, 1'b0);
        cyc(7'b1000001, 1'b1);
        repeat (3) cyc(7'b0000001, 1'b0);
        cyc(7'b0000001, 1'b1);
        cyc('0, 1'b0);

        // Async reset in the middle of a grant.
        cyc(7'b0010000, 1'b0);
        cyc(7'b0010000, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (4) cyc(7'b0010001, 1'b0);
        cyc('0, 1'b0);
        cyc(7'b0000100, 1'b0);
        cyc('0, 1'b0);

        // Randomized traffic: requests held for stretches, occasional done.
        r = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: r = 7'h7F;
                    1: r = N'(1) << $urandom_range(0, N - 1);
                    2: r = '0;
                    default: r = N'($urandom);
                endcase
            end
            d = ($urandom_range(0, 5) == 0);
            cyc(r, d);
        end
        cyc('0, 1'b0);
        cyc('0, 1'b0);

        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_hot_arbiter.md
Name: rr_hot_arbiter

Overview:
- Round-robin arbiter sharing one resource among N_REQ requesters.
- Issues a registered one-hot grant vector, plus a matching 3-bit grant index in the Hot encoder convention: index 0 = no grant, index k = bit k-1.
- Optional Gray-coded index output for the Gray encoder path.
- Bounds each grant tenure to MAX_HOLD cycles.

Parameters:
- N_REQ, 7, number of requesters; fixed range 2..7 so the index fits 3 bits.
- MAX_HOLD, 4, maximum cycles a grant stays asserted (>=1).
- USE_GRAY, 0, 1 = grant_code is the Gray code of grant_idx; 0 = grant_code equals grant_idx.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  N_REQ  request per requester; held high until served.
- done  input  1  holder finished; releases the current grant.
- grant  output  N_REQ  one-hot grant; all-zero when idle; registered.
- grant_idx  output  3  0 = none, k = grant[k-1] set; registered.
- grant_code  output  3  grant_idx, or its Gray code (idx ^ (idx>>1)) when USE_GRAY=1.
- busy  output  1  high while in GRANT state.
- timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - grant, grant_idx, grant_code, busy, timeout all 0.
  - state=IDLE, ptr=0, tenure=0.
- State machine: IDLE, GRANT.
- IDLE:
  - If req != 0 at the edge: winner = first set req bit, searching upward from ptr with wrap-around (ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1).
  - Next: state=GRANT, grant=1<<winner, grant_idx=winner+1, tenure=1, busy=1.
  - If req == 0: remain IDLE, outputs 0.
- GRANT, evaluated each edge with w = current winner:
  - Release if req[w]==0, OR done==1, OR tenure==MAX_HOLD.
  - On release: state=IDLE; grant, grant_idx and busy return to 0; ptr=(w+1) mod N_REQ.
  - Otherwise: tenure increments; outputs hold.
- timeout pulses for one cycle, coincident with the first IDLE cycle, only when release is caused solely by tenure==MAX_HOLD, i.e. req[w]==1 and done==0.
- Simultaneous release causes (req drop and done, or done and tenure==MAX_HOLD with done=1): single release; no timeout pulse.
- Latency: request sampled at edge k -> grant visible after edge k. Grant visible for at most MAX_HOLD cycles.
- Minimum one idle cycle (grant=0) between consecutive grants, including back-to-back requests from the same requester.
- Requests arriving or dropping for non-granted requesters during GRANT have no effect until IDLE.
- Requester w re-requesting after release has lowest priority next round (ptr moved past it).
- grant is never multi-hot. grant_idx and grant_code are always consistent with grant in the same cycle.

Test Plan:
- Reset: hold rst_n=0 with req=7'h7F -> all outputs 0; release rst_n, req=0 -> stays idle, grant=0.
- Single request: req=7'b0000100 one edge -> next cycle grant=7'b0000100, grant_idx=3, busy=1; drop req -> following cycle grant=0, idx=0, timeout=0.
- Fairness/timeout: req=7'h7F held, done=0, MAX_HOLD=4:
  - grant_idx sequence is 1,2,3,4,5,6,7,1.
  - Each grant lasts exactly 4 cycles and is followed by one idle cycle with timeout=1.
- Wrap and done: after serving idx 6 (ptr=6), req=7'b1000001 -> idx 7 wins; done=1 after 2 cycles -> release with timeout=0; next winner idx 1 (bit 0).
- Async reset mid-grant: during grant idx 5, pull rst_n low between edges -> outputs 0 immediately; after release with req=7'b0010001, idx 1 wins (ptr reset to 0).
- Gray mode (USE_GRAY=1): req=7'b0010000 -> grant_idx=5, grant_code=3'b111; req=7'b0000100 -> grant_code=3'b010.
